// File: rtl/ast_rr_mux_if.sv
// Boundary of the N:1 packet mux: RX_DIR Avalon-ST sinks on the input side, one merged
// Avalon-ST source plus the source-port index on the output side.
interface ast_rr_mux_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int CHANNEL_WIDTH = 10,
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
);
    logic [DATA_WIDTH-1:0]    ast_data_i [RX_DIR];
    logic [RX_DIR-1:0]        ast_startofpacket_i;
    logic [RX_DIR-1:0]        ast_endofpacket_i;
    logic [RX_DIR-1:0]        ast_valid_i;
    logic [EMPTY_WIDTH-1:0]   ast_empty_i [RX_DIR];
    logic [CHANNEL_WIDTH-1:0] ast_channel_i [RX_DIR];
    logic [RX_DIR-1:0]        ast_ready_o;

    logic [DATA_WIDTH-1:0]    ast_data_o;
    logic                     ast_startofpacket_o;
    logic                     ast_endofpacket_o;
    logic                     ast_valid_o;
    logic [EMPTY_WIDTH-1:0]   ast_empty_o;
    logic [CHANNEL_WIDTH-1:0] ast_channel_o;
    logic [DIR_SEL_WIDTH-1:0] src_o;
    logic                     ast_ready_i;

    modport slave (
        input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
               ast_empty_i, ast_channel_i, ast_ready_i,
        output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_valid_o, ast_empty_o, ast_channel_o, src_o
    );

    modport master (
        output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
               ast_empty_i, ast_channel_i, ast_ready_i,
        input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_valid_o, ast_empty_o, ast_channel_o, src_o
    );
endinterface

// File: rtl/ast_rr_mux.sv
// Packet-locked round-robin N:1 Avalon-ST mux; 1-cycle latency through one output register,
// one idle grant cycle per packet; input ready = output register free, full throughput in a packet.
module ast_rr_mux #(
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int CHANNEL_WIDTH = 10,
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic        clk_i,
    input  logic        srst_i,
    ast_rr_mux_if.slave ast
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                   state_q, state_d;
    // ptr_q doubles as the grant: after a grant the round-robin pointer equals the winner.
    logic [DIR_SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [DIR_SEL_WIDTH-1:0] src_q, src_d;
    logic [DIR_SEL_WIDTH-1:0] cand;
    logic                     found;
    logic                     out_free;
    logic [RX_DIR-1:0]        ready_vec;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     sop_q, sop_d;
    logic                     eop_q, eop_d;
    logic                     valid_q, valid_d;
    logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        valid_d   = valid_q;
        empty_d   = empty_q;
        channel_d = channel_q;
        ready_vec = '0;
        cand      = '0;
        found     = 1'b0;
        out_free  = !valid_q || ast.ast_ready_i;

        if (out_free) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                for (int i = 1; i <= RX_DIR; i++) begin
                    cand = DIR_SEL_WIDTH'((int'(ptr_q) + i) % RX_DIR);
                    if (!found && ast.ast_valid_i[cand]) begin
                        found   = 1'b1;
                        ptr_d   = cand;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                ready_vec[ptr_q] = out_free;
                if (out_free && ast.ast_valid_i[ptr_q]) begin
                    data_d    = ast.ast_data_i[ptr_q];
                    sop_d     = ast.ast_startofpacket_i[ptr_q];
                    eop_d     = ast.ast_endofpacket_i[ptr_q];
                    empty_d   = ast.ast_empty_i[ptr_q];
                    channel_d = ast.ast_channel_i[ptr_q];
                    src_d     = ptr_q;
                    valid_d   = 1'b1;
                    if (ast.ast_endofpacket_i[ptr_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            ptr_q     <= DIR_SEL_WIDTH'(RX_DIR - 1);
            src_q     <= '0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            valid_q   <= 1'b0;
            empty_q   <= '0;
            channel_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            valid_q   <= valid_d;
            empty_q   <= empty_d;
            channel_q <= channel_d;
        end
    end

    assign ast.ast_ready_o         = ready_vec;
    assign ast.ast_data_o          = data_q;
    assign ast.ast_startofpacket_o = sop_q;
    assign ast.ast_endofpacket_o   = eop_q;
    assign ast.ast_valid_o         = valid_q;
    assign ast.ast_empty_o         = empty_q;
    assign ast.ast_channel_o       = channel_q;
    assign ast.src_o               = src_q;
endmodule

// File: tb/tb_ast_rr_mux.sv
// Scoreboard bench for ast_rr_mux: per-port packet queues feed the inputs, a queue-based
// round-robin model predicts the merged beat stream, a negedge monitor pops and compares.
module tb_ast_rr_mux;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 10;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int XW = DW + 2 + EW + CW + SW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [CW-1:0] channel;
    } beat_t;

    logic clk = 1'b0;
    logic srst = 1'b1;

    ast_rr_mux_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW),
                    .RX_DIR(N), .DIR_SEL_WIDTH(SW)) bus ();

    ast_rr_mux #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW),
                 .RX_DIR(N), .DIR_SEL_WIDTH(SW)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .ast    (bus)
    );

    initial forever #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    beat_t port_q [N][$];
    logic [XW-1:0] exp_q [$];
    int model_ptr = N - 1;
    int rdy_mode = 0;
    int pat_cnt = 0;
    int phase = 0;
    bit mon_en = 1'b0;
    bit gap_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int p, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data    = {$urandom, $urandom};
            b.sop     = (k == 0);
            b.eop     = (k == len - 1);
            b.empty   = b.eop ? EW'($urandom_range(0, 7)) : '0;
            b.channel = CW'($urandom_range(0, 1023));
            port_q[p].push_back(b);
        end
    endtask

    // Round robin over whole packets: after the last winner, the next port with a pending packet.
    task automatic build_expected();
        beat_t tmp [N][$];
        beat_t b;
        int remaining = 0;
        int pick;
        int c;
        for (int p = 0; p < N; p++) begin
            tmp[p] = port_q[p];
            remaining += tmp[p].size();
        end
        while (remaining > 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_ptr + k) % N;
                if (pick < 0 && tmp[c].size() > 0) pick = c;
            end
            model_ptr = pick;
            do begin
                b = tmp[pick].pop_front();
                remaining--;
                exp_q.push_back({b.data, b.sop, b.eop, b.empty, b.channel, SW'(pick)});
            end while (!b.eop && tmp[pick].size() > 0);
        end
    endtask

    task automatic drive_ports();
        beat_t b;
        for (int p = 0; p < N; p++) begin
            if (port_q[p].size() > 0) begin
                b = port_q[p][0];
                bus.ast_valid_i[p]         = 1'b1;
                bus.ast_data_i[p]          = b.data;
                bus.ast_startofpacket_i[p] = b.sop;
                bus.ast_endofpacket_i[p]   = b.eop;
                bus.ast_empty_i[p]         = b.empty;
                bus.ast_channel_i[p]       = b.channel;
            end else begin
                bus.ast_valid_i[p]         = 1'b0;
                bus.ast_data_i[p]          = '0;
                bus.ast_startofpacket_i[p] = 1'b0;
                bus.ast_endofpacket_i[p]   = 1'b0;
                bus.ast_empty_i[p]         = '0;
                bus.ast_channel_i[p]       = '0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] fire;
        beat_t d;
        @(negedge clk);
        fire = bus.ast_valid_i & bus.ast_ready_o;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (fire[p] && port_q[p].size() > 0) d = port_q[p].pop_front();
        end
        pat_cnt++;
        case (rdy_mode)
            0:       bus.ast_ready_i = 1'b1;
            1:       bus.ast_ready_i = (pat_cnt % 3 == 0);
            default: bus.ast_ready_i = ($urandom_range(0, 9) < 7);
        endcase
        drive_ports();
    endtask

    function automatic bit ports_busy();
        bit r = 1'b0;
        for (int p = 0; p < N; p++) if (port_q[p].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ports_busy()) && n < 3000) begin
            step();
            n++;
        end
        check(name, (exp_q.size() == 0) && !ports_busy(), 1);
        repeat (3) step();
    endtask

    task automatic start_phase(input int mode, input bit gaps);
        phase++;
        rdy_mode = mode;
        gap_en = gaps;
        pat_cnt = 0;
        bus.ast_ready_i = 1'b1;
    endtask

    // Monitor: one comparison per accepted output beat, plus hold and spacing checks.
    int cyc = 0;
    int last_phase = 0;
    int prev_cyc = 0;
    bit have_prev = 1'b0;
    bit prev_eop = 1'b0;
    bit held_vld = 1'b0;
    logic [XW-1:0] held;
    logic [XW-1:0] act;
    logic [XW-1:0] e;

    always @(negedge clk) begin
        cyc++;
        if (phase != last_phase) begin
            last_phase = phase;
            have_prev = 1'b0;
            held_vld = 1'b0;
        end
        if (!mon_en || !bus.ast_valid_o) begin
            held_vld = 1'b0;
        end else begin
            act = {bus.ast_data_o, bus.ast_startofpacket_o, bus.ast_endofpacket_o,
                   bus.ast_empty_o, bus.ast_channel_o, bus.src_o};
            if (held_vld) check("hold_stable", act, held);
            if (bus.ast_ready_i) begin
                held_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    check("beat_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", act, e);
                    if (gap_en && have_prev) check("beat_spacing", cyc - prev_cyc, prev_eop ? 2 : 1);
                    have_prev = 1'b1;
                    prev_cyc = cyc;
                    prev_eop = bus.ast_endofpacket_o;
                end
            end else begin
                held_vld = 1'b1;
                held = act;
            end
        end
    end

    initial begin
        int n;
        bus.ast_ready_i = 1'b0;
        // Reset with every input valid: nothing may be accepted or presented.
        for (int p = 0; p < N; p++) begin
            bus.ast_valid_i[p]         = 1'b1;
            bus.ast_data_i[p]          = {$urandom, $urandom};
            bus.ast_startofpacket_i[p] = 1'b1;
            bus.ast_endofpacket_i[p]   = 1'b1;
            bus.ast_empty_i[p]         = '0;
            bus.ast_channel_i[p]       = CW'(p);
        end
        srst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_valid_o", bus.ast_valid_o, 0);
            check("rst_ready_o", bus.ast_ready_o, 0);
            check("rst_src_o", bus.src_o, 0);
            check("rst_data_o", bus.ast_data_o, 0);
        end
        srst = 1'b0;
        drive_ports();
        mon_en = 1'b1;

        // Four 3-beat packets offered together: expect ports 0,1,2,3 in order.
        start_phase(0, 1'b1);
        for (int p = 0; p < N; p++) add_pkt(p, 3);
        build_expected();
        drive_ports();
        drain("drain_all_ports");

        // Two single-beat packets on port 2 back to back.
        start_phase(0, 1'b1);
        add_pkt(2, 1);
        add_pkt(2, 1);
        build_expected();
        drive_ports();
        drain("drain_port2_singles");

        // 4-beat packet on port 1 under a 1,0,0 ready pattern.
        start_phase(1, 1'b0);
        add_pkt(1, 4);
        build_expected();
        drive_ports();
        drain("drain_backpressure");

        // Port 3 wins, then ports 0 and 3 compete: pointer wraps to 0.
        start_phase(0, 1'b1);
        add_pkt(3, 2);
        build_expected();
        drive_ports();
        drain("drain_port3");
        start_phase(0, 1'b1);
        add_pkt(3, 2);
        add_pkt(0, 2);
        build_expected();
        drive_ports();
        drain("drain_wrap");

        // Reset in the middle of a port 0 packet.
        start_phase(0, 1'b0);
        mon_en = 1'b0;
        add_pkt(0, 4);
        drive_ports();
        n = 0;
        while (port_q[0].size() > 2 && n < 50) begin
            step();
            n++;
        end
        check("midpkt_reached", port_q[0].size(), 2);
        srst = 1'b1;
        step();
        check("midrst_valid_o", bus.ast_valid_o, 0);
        check("midrst_ready_o", bus.ast_ready_o, 0);
        srst = 1'b0;
        for (int p = 0; p < N; p++) port_q[p].delete();
        exp_q.delete();
        model_ptr = N - 1;
        drive_ports();
        step();
        start_phase(0, 1'b1);
        mon_en = 1'b1;
        add_pkt(1, 2);
        add_pkt(3, 1);
        add_pkt(0, 3);
        build_expected();
        drive_ports();
        drain("drain_after_reset");

        // Randomised traffic with random backpressure.
        for (int r = 0; r < 8; r++) begin
            start_phase(2, 1'b0);
            for (int p = 0; p < N; p++) begin
                int np = $urandom_range(0, 3);
                for (int k = 0; k < np; k++) add_pkt(p, $urandom_range(1, 5));
            end
            build_expected();
            drive_ports();
            drain("drain_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
